multicycle_controller: RTL and testbench

Control sequencer for the multi-cycle build of the CPU. It replaces the single-cycle controller and steps the shared datapath (register bank, ALU, data memory, writeback mux, PC) through FETCH/DECODE/EXEC/MEM/WB states. Both memories are reached over a req/ready handshake, so memory may take any number of cycles to respond. The block also provides a halt point at instruction boundaries, a memory-timeout fault and a retired-instruction counter.

---
 rtl/multicycle_controller_if.sv | 38 +++
 rtl/multicycle_controller.sv | 174 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle sequencer and the shared datapath/memories.
// master = controller side, slave = datapath/memory side.
interface multicycle_controller_if;
  logic [31:0] instruction;
  logic        zero;
  logic        imem_ready;
  logic        dmem_ready;
  logic        halt_req;
  logic        imem_req;
  logic        ir_write;
  logic        dmem_req;
  logic        mem_write;
  logic        mem_read;
  logic        alu_src_b;
  logic [1:0]  alu_op;
  logic        reg_write;
  logic        mem_to_reg;
  logic        pc_write;
  logic        pc_src;
  logic        halted;
  logic        illegal_instr;
  logic        fault;
  logic [31:0] instr_count;

  modport master (
    input  instruction, zero, imem_ready, dmem_ready, halt_req,
    output imem_req, ir_write, dmem_req, mem_write, mem_read, alu_src_b, alu_op,
           reg_write, mem_to_reg, pc_write, pc_src, halted, illegal_instr, fault,
           instr_count
  );

  modport slave (
    output instruction, zero, imem_ready, dmem_ready, halt_req,
    input  imem_req, ir_write, dmem_req, mem_write, mem_read, alu_src_b, alu_op,
           reg_write, mem_to_reg, pc_write, pc_src, halted, illegal_instr, fault,
           instr_count
  );
endinterface

// File: rtl/multicycle_controller.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle CPU with req/ready memories,
// instruction-boundary halt, memory-timeout fault and a retired-instruction counter.
module multicycle_controller #(
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master bus
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_FAULT
  } state_t;

  state_t            state_q, state_d;
  logic              pending_q, pending_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [31:0]       count_q, count_d;

  logic [6:0] opcode;
  logic       is_r, is_i, is_ld, is_st, is_br, is_legal;
  logic       retire;
  logic       req_waiting;
  logic       unused_instr_bits;

  assign opcode            = bus.instruction[6:0];
  assign unused_instr_bits = ^bus.instruction[31:7];
  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_ld    = (opcode == OP_LOAD);
  assign is_st    = (opcode == OP_STORE);
  assign is_br    = (opcode == OP_BRANCH);
  assign is_legal = is_r | is_i | is_ld | is_st | is_br;

  assign bus.instr_count = count_q;

  always_comb begin
    bus.imem_req      = 1'b0;
    bus.ir_write      = 1'b0;
    bus.dmem_req      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_read      = 1'b0;
    bus.alu_src_b     = 1'b0;
    bus.alu_op        = 2'b00;
    bus.reg_write     = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_src        = 1'b0;
    bus.halted        = 1'b0;
    bus.illegal_instr = 1'b0;
    bus.fault         = 1'b0;
    state_d           = state_q;
    pending_d         = pending_q;
    wait_d            = wait_q;
    retire            = 1'b0;
    req_waiting       = 1'b0;

    case (state_q)
      S_FETCH: begin
        // A fetch already on the bus must complete even if halt_req arrives.
        if (bus.halt_req && !pending_q) begin
          bus.halted = 1'b1;
        end else begin
          bus.imem_req = 1'b1;
          if (bus.imem_ready) begin
            bus.ir_write = 1'b1;
            pending_d    = 1'b0;
            state_d      = S_DECODE;
          end else begin
            pending_d   = 1'b1;
            req_waiting = 1'b1;
          end
        end
      end
      S_DECODE: begin
        if (is_legal) begin
          state_d = S_EXEC;
        end else begin
          bus.illegal_instr = 1'b1;
          bus.pc_write      = 1'b1;
          state_d           = S_FETCH;
        end
      end
      S_EXEC: begin
        if (is_r || is_i) begin
          bus.alu_op    = 2'b10;
          bus.alu_src_b = is_i;
          state_d       = S_WB;
        end else if (is_ld || is_st) begin
          bus.alu_src_b = 1'b1;
          state_d       = S_MEM;
        end else begin
          bus.alu_op   = 2'b01;
          bus.pc_write = 1'b1;
          bus.pc_src   = bus.zero;
          retire       = is_br;
          state_d      = S_FETCH;
        end
      end
      S_MEM: begin
        bus.dmem_req  = 1'b1;
        bus.mem_read  = is_ld;
        bus.mem_write = is_st;
        if (bus.dmem_ready) begin
          if (is_st) begin
            bus.pc_write = 1'b1;
            retire       = 1'b1;
            state_d      = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else begin
          req_waiting = 1'b1;
        end
      end
      S_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = is_ld;
        bus.pc_write   = 1'b1;
        retire         = 1'b1;
        state_d        = S_FETCH;
      end
      S_FAULT: begin
        bus.fault = 1'b1;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase

    if (req_waiting) begin
      wait_d = wait_q + 1'b1;
      if ((TIMEOUT != 0) && (wait_q == WAIT_LAST)) begin
        state_d = S_FAULT;
      end
    end

    // Each new memory phase starts with a fresh wait budget.
    if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) begin
      wait_d = '0;
    end

    count_d = count_q + 32'(retire);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pending_q <= 1'b0;
      wait_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      wait_q    <= wait_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed plus randomized instruction stream checked cycle by cycle against an
// instruction-level table of expected control vectors.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_controller_if bus_if ();

  multicycle_controller #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  localparam logic [14:0] IMEM_REQ   = 15'h4000;
  localparam logic [14:0] IR_WRITE   = 15'h2000;
  localparam logic [14:0] DMEM_REQ   = 15'h1000;
  localparam logic [14:0] MEM_WRITE  = 15'h0800;
  localparam logic [14:0] MEM_READ   = 15'h0400;
  localparam logic [14:0] ALU_SRC_B  = 15'h0200;
  localparam logic [14:0] ALUOP_10   = 15'h0100;
  localparam logic [14:0] ALUOP_01   = 15'h0080;
  localparam logic [14:0] REG_WRITE  = 15'h0040;
  localparam logic [14:0] MEM_TO_REG = 15'h0020;
  localparam logic [14:0] PC_WRITE   = 15'h0010;
  localparam logic [14:0] PC_SRC     = 15'h0008;
  localparam logic [14:0] HALTED     = 15'h0004;
  localparam logic [14:0] ILLEGAL    = 15'h0002;
  localparam logic [14:0] FAULT      = 15'h0001;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_ADDI = 32'h00108093;
  localparam logic [31:0] I_LW   = 32'h0000A283;
  localparam logic [31:0] I_SW   = 32'h0050A223;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

  int          nerr = 0;
  int          nchk = 0;
  logic [31:0] exp_count = 32'd0;

  wire [14:0] vec = {bus_if.imem_req, bus_if.ir_write, bus_if.dmem_req, bus_if.mem_write,
                     bus_if.mem_read, bus_if.alu_src_b, bus_if.alu_op, bus_if.reg_write,
                     bus_if.mem_to_reg, bus_if.pc_write, bus_if.pc_src, bus_if.halted,
                     bus_if.illegal_instr, bus_if.fault};

  task automatic check_vec(input string tag, input logic [14:0] got, input logic [14:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: ctrl observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_count(input string tag);
    nchk++;
    assert (bus_if.instr_count === exp_count) else begin
      nerr++;
      $error("FAIL %s: instr_count observed=%0d expected=%0d", tag, bus_if.instr_count, exp_count);
    end
  endtask

  // One clock cycle: drive readies/halt, check the vector mid-cycle, advance past the edge.
  task automatic step(input logic [14:0] exp, input logic ir, input logic dr, input logic h,
                      input string tag);
    bus_if.imem_ready = ir;
    bus_if.dmem_ready = dr;
    bus_if.halt_req   = h;
    @(negedge clk);
    check_vec(tag, vec, exp);
    @(posedge clk);
    #1;
  endtask

  // Walks one instruction through the phases the class requires; iw/dw are wait cycles.
  task automatic run_instr(input logic [31:0] ins, input int iw, input int dw, input logic z,
                           input logic halt_mid, input string tag);
    logic is_r, is_i, is_ld, is_st, is_br;
    is_r  = (ins[6:0] == 7'b0110011);
    is_i  = (ins[6:0] == 7'b0010011);
    is_ld = (ins[6:0] == 7'b0000011);
    is_st = (ins[6:0] == 7'b0100011);
    is_br = (ins[6:0] == 7'b1100011);
    bus_if.instruction = ins;
    bus_if.zero        = z;
    for (int k = 0; k < iw; k++) step(IMEM_REQ, 1'b0, 1'b0, halt_mid && (k >= 1), {tag, ".fetch_wait"});
    step(IMEM_REQ | IR_WRITE, 1'b1, 1'b0, halt_mid && (iw >= 1), {tag, ".fetch"});
    if (!(is_r || is_i || is_ld || is_st || is_br)) begin
      step(ILLEGAL | PC_WRITE, 1'b0, 1'b0, 1'b0, {tag, ".decode_illegal"});
    end else begin
      step(15'h0, 1'b0, 1'b0, 1'b0, {tag, ".decode"});
      if (is_br) begin
        step(ALUOP_01 | PC_WRITE | (z ? PC_SRC : 15'h0), 1'b0, 1'b0, 1'b0, {tag, ".exec_br"});
        exp_count++;
      end else if (is_r || is_i) begin
        step(ALUOP_10 | (is_i ? ALU_SRC_B : 15'h0), 1'b0, 1'b0, 1'b0, {tag, ".exec_alu"});
        step(REG_WRITE | PC_WRITE, 1'b0, 1'b0, 1'b0, {tag, ".wb"});
        exp_count++;
      end else begin
        step(ALU_SRC_B, 1'b0, 1'b0, 1'b0, {tag, ".exec_addr"});
        for (int k = 0; k < dw; k++)
          step(DMEM_REQ | (is_ld ? MEM_READ : MEM_WRITE), 1'b0, 1'b0, 1'b0, {tag, ".mem_wait"});
        step(DMEM_REQ | (is_ld ? MEM_READ : (MEM_WRITE | PC_WRITE)), 1'b0, 1'b1, 1'b0, {tag, ".mem"});
        if (is_ld) step(REG_WRITE | MEM_TO_REG | PC_WRITE, 1'b0, 1'b0, 1'b0, {tag, ".wb"});
        exp_count++;
      end
    end
    check_count({tag, ".count"});
  endtask

  function automatic logic [31:0] gen_instr(input int cls);
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom;
    case (cls)
      0: op = 7'b0110011;
      1: op = 7'b0010011;
      2: op = 7'b0000011;
      3: op = 7'b0100011;
      4: op = 7'b1100011;
      default: begin
        op = 7'($urandom);
        while (op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
               op == 7'b0100011 || op == 7'b1100011)
          op = 7'($urandom);
      end
    endcase
    r[6:0] = op;
    return r;
  endfunction

  initial begin
    reset              = 1'b1;
    bus_if.instruction = 32'h0;
    bus_if.zero        = 1'b0;
    bus_if.imem_ready  = 1'b0;
    bus_if.dmem_ready  = 1'b0;
    bus_if.halt_req    = 1'b0;
    #12;
    check_vec("reset.outputs", vec, IMEM_REQ);
    check_count("reset.count");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_instr(I_ADD, 0, 0, 1'b0, 1'b0, "add");
    run_instr(I_LW,  0, 3, 1'b0, 1'b0, "lw");
    run_instr(I_SW,  0, 0, 1'b0, 1'b0, "sw");
    run_instr(I_BEQ, 0, 0, 1'b1, 1'b0, "beq_taken");
    run_instr(I_BEQ, 0, 0, 1'b0, 1'b0, "beq_not_taken");
    run_instr(I_BAD, 0, 0, 1'b0, 1'b0, "illegal");

    for (int k = 0; k < 3; k++) step(HALTED, 1'b0, 1'b0, 1'b1, "halt.parked");
    run_instr(I_ADDI, 0, 0, 1'b0, 1'b0, "halt.resume");
    run_instr(I_ADDI, 2, 0, 1'b0, 1'b1, "halt.after_req");
    run_instr(I_ADD, 1, 0, 1'b0, 1'b0, "post_halt");

    for (int n = 0; n < 40; n++) begin
      run_instr(gen_instr($urandom_range(0, 5)), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), 1'b0, $sformatf("rnd%0d", n));
    end

    bus_if.instruction = I_ADD;
    for (int k = 0; k < 4; k++) step(IMEM_REQ, 1'b0, 1'b0, 1'b0, "timeout.wait");
    step(FAULT, 1'b0, 1'b0, 1'b0, "timeout.fault");
    step(FAULT, 1'b1, 1'b1, 1'b1, "timeout.sticky_ready");
    step(FAULT, 1'b0, 1'b0, 1'b0, "timeout.sticky");
    check_count("timeout.count");

    reset     = 1'b1;
    exp_count = 32'd0;
    #2;
    check_vec("reset2.outputs", vec, IMEM_REQ);
    check_count("reset2.count");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_instr(I_ADD, 0, 0, 1'b0, 1'b0, "after_reset.add");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
